mem_stage_lsu: RTL

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/load_align.sv | 26 ++
 rtl/mem_stage_lsu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds funct3 size codes, the FSM states and the request/write-back bundles.
package mem_stage_pkg;

   localparam int ACK_TIMEOUT_DEF = 15;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] alu;
      logic [3:0]  be;
      logic [2:0]  f3;
      logic        we;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
   } req_t;

   typedef struct packed {
      logic        valid;
      logic        rw;
      logic        m2r;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        berr;
   } wb_t;

   function automatic logic is_aligned(input logic [2:0] f3,
                                       input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return ~off[0];
         2'b10:   return off == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword from a read word.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [15:0] lane;

   assign lane = 16'(rdata >> {offset, 3'b000});

   always_comb begin
      result = rdata;
      case (funct3)
         F3_B:    result = {{24{lane[7]}}, lane[7:0]};
         F3_H:    result = {{16{lane[15]}}, lane};
         F3_BU:   result = {24'h0, lane[7:0]};
         F3_HU:   result = {16'h0, lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory access,
// ack timeout, misalignment detection and a registered write-back slot.
module mem_stage_lsu
   import mem_stage_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ex_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   input  logic        mem_to_reg,
   input  logic [31:0] alu_result,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic        wb_mem_to_reg,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_error
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   req_t          req_q, req_d;
   wb_t           wb_q, wb_d;

   logic          mem_op;
   logic          aligned;
   logic          accept;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [31:0]   load_val;

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .offset (req_q.addr[1:0]),
      .funct3 (req_q.f3),
      .result (load_val)
   );

   assign mem_op  = mem_read | mem_write;
   assign aligned = is_aligned(funct3, addr[1:0]);
   assign accept  = (state_q == IDLE) & ex_valid & mem_op & aligned;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = wdata;
      case (funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << addr[1:0];
            st_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << addr[1:0];
            st_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      wb_d    = wb_q;
      wb_d.valid = 1'b0;
      wb_d.mis   = 1'b0;
      wb_d.berr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_valid && !mem_op) begin
               wb_d = '{1'b1, reg_write, mem_to_reg, rd,
                        alu_result, 1'b0, 1'b0};
            end else if (ex_valid && !aligned) begin
               wb_d = '{1'b1, 1'b0, mem_to_reg, rd,
                        alu_result, 1'b1, 1'b0};
            end else if (accept) begin
               req_d = '{addr, st_wdata, alu_result, st_be, funct3,
                         mem_write, rd, reg_write, mem_to_reg};
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (dmem_ack) begin
               wb_d = '{1'b1, req_q.rw & ~req_q.we, req_q.m2r, req_q.rd,
                        req_q.we ? req_q.alu : load_val, 1'b0, 1'b0};
               state_d = RESP;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               wb_d = '{1'b1, 1'b0, req_q.m2r, req_q.rd,
                        32'h0, 1'b0, 1'b1};
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         wb_q    <= wb_d;
      end
   end

   assign dmem_req   = (state_q == ACCESS);
   assign dmem_we    = dmem_req & req_q.we;
   assign dmem_addr  = {req_q.addr[31:2], 2'b00};
   assign dmem_wdata = req_q.wdata;
   assign dmem_be    = req_q.be;

   // Gated by Reset so the upstream hold drops without waiting for an edge.
   assign stall = ~Reset & (accept | (state_q == ACCESS));

   assign wb_valid      = wb_q.valid;
   assign wb_reg_write  = wb_q.rw;
   assign wb_mem_to_reg = wb_q.m2r;
   assign wb_rd         = wb_q.rd;
   assign wb_data       = wb_q.data;
   assign misaligned    = wb_q.mis;
   assign bus_error     = wb_q.berr;

endmodule
